// File: rtl/ucsbece154b_perfmon_if.sv
// Probe and counter-read bundle for the dual-issue performance monitor.
// The core (or a bench) drives the probe/read-request side through the
// master modport; the monitor sits on the slave modport.
interface ucsbece154b_perfmon_if #(
    parameter int CNT_W = 32
);
    // Control
    logic             start_i;
    logic             clear_i;

    // Decode stage
    logic [31:0]      InstrD_i;
    logic [31:0]      InstrD2_i;

    // Execute stage
    logic [6:0]       opE_i;
    logic [6:0]       opE2_i;
    logic             Mispredict_i;
    logic             Mispredict2_i;

    // Fetch stage
    logic             BranchTakenF_i;
    logic             BranchTakenF2_i;
    logic [31:0]      PCF_i;
    logic [31:0]      PCF2_i;
    logic [31:0]      InstrF_i;
    logic [31:0]      InstrF2_i;

    // Read port and status
    logic             rd_en_i;
    logic [2:0]       rd_addr_i;
    logic [CNT_W-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             halted_o;
    logic             timeout_o;

    modport master (
        output start_i, clear_i,
        output InstrD_i, InstrD2_i,
        output opE_i, opE2_i, Mispredict_i, Mispredict2_i,
        output BranchTakenF_i, BranchTakenF2_i,
        output PCF_i, PCF2_i, InstrF_i, InstrF2_i,
        output rd_en_i, rd_addr_i,
        input  rd_data_o, rd_valid_o, halted_o, timeout_o
    );

    modport slave (
        input  start_i, clear_i,
        input  InstrD_i, InstrD2_i,
        input  opE_i, opE2_i, Mispredict_i, Mispredict2_i,
        input  BranchTakenF_i, BranchTakenF2_i,
        input  PCF_i, PCF2_i, InstrF_i, InstrF2_i,
        input  rd_en_i, rd_addr_i,
        output rd_data_o, rd_valid_o, halted_o, timeout_o
    );
endinterface

// File: rtl/ucsbece154b_perfmon.sv
// In-core performance monitor for the dual-issue pipeline.
// Accumulates saturating event counters while running, freezes them when
// both fetch slots spin on a NOP at an unchanged PC (HALTED) or when the
// cycle budget is exhausted (TIMEOUT), and exposes everything through a
// one-cycle-latency registered read port. CNT_W must be at least 4 so the
// status word fits.
module ucsbece154b_perfmon #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    ucsbece154b_perfmon_if.slave bus
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t           state;

    // Event counters
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ins_cnt;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] brm_cnt;
    logic [CNT_W-1:0] jmp_cnt;
    logic [CNT_W-1:0] jmpm_cnt;

    // Saturated candidates for the next counted cycle
    logic [CNT_W-1:0] cyc_next;
    logic [CNT_W-1:0] ins_next;
    logic [CNT_W-1:0] br_next;
    logic [CNT_W-1:0] brm_next;
    logic [CNT_W-1:0] jmp_next;
    logic [CNT_W-1:0] jmpm_next;

    // Per-cycle event increments (0, 1 or 2 each)
    logic [1:0]       ins_inc;
    logic [1:0]       br_inc;
    logic [1:0]       brm_inc;
    logic [1:0]       jmp_inc;
    logic [1:0]       jmpm_inc;

    logic [31:0]      prev_pc1;
    logic [31:0]      prev_pc2;
    logic [31:0]      halt_pc;

    logic             halt_cond;
    logic             budget_hit;

    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_mux;

    // A decode slot carries real work unless it is empty or the canonical NOP.
    function automatic logic is_issued(input logic [31:0] instr);
        return (instr != '0) && (instr != NOP);
    endfunction

    function automatic logic is_jump(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // Add 0..2 with clamping at all-ones; the extra carry bit flags overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] value,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, value} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Per-slot event classification for the current cycle.
    always_comb begin
        ins_inc  = {1'b0, is_issued(bus.InstrD_i)} + {1'b0, is_issued(bus.InstrD2_i)};

        br_inc   = {1'b0, (bus.opE_i  == OP_BRANCH)}
                 + {1'b0, (bus.opE2_i == OP_BRANCH)};

        brm_inc  = {1'b0, (bus.opE_i  == OP_BRANCH) && bus.Mispredict_i}
                 + {1'b0, (bus.opE2_i == OP_BRANCH) && bus.Mispredict2_i};

        jmp_inc  = {1'b0, is_jump(bus.opE_i)} + {1'b0, is_jump(bus.opE2_i)};

        jmpm_inc = {1'b0, is_jump(bus.opE_i)  && !bus.BranchTakenF_i}
                 + {1'b0, is_jump(bus.opE2_i) && !bus.BranchTakenF2_i};
    end

    // Saturated next values, end-of-program detection and budget check.
    always_comb begin
        cyc_next   = sat_add(cyc_cnt,  2'd1);
        ins_next   = sat_add(ins_cnt,  ins_inc);
        br_next    = sat_add(br_cnt,   br_inc);
        brm_next   = sat_add(brm_cnt,  brm_inc);
        jmp_next   = sat_add(jmp_cnt,  jmp_inc);
        jmpm_next  = sat_add(jmpm_cnt, jmpm_inc);

        halt_cond  = (bus.PCF_i  == prev_pc1) && (bus.InstrF_i  == NOP)
                  && (bus.PCF2_i == prev_pc2) && (bus.InstrF2_i == NOP);

        // Widen both sides so narrow counters compare correctly against the budget.
        budget_hit = 64'(cyc_next) >= 64'(MAX_CYCLES);
    end

    // Control FSM with counters, halt PC and registered state decodes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            ins_cnt  <= '0;
            br_cnt   <= '0;
            brm_cnt  <= '0;
            jmp_cnt  <= '0;
            jmpm_cnt <= '0;
            halt_pc  <= '0;
            halted   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            // Flags follow the state one cycle late.
            halted  <= (state == HALTED);
            timeout <= (state == TIMEOUT);

            if (bus.clear_i) begin
                cyc_cnt  <= '0;
                ins_cnt  <= '0;
                br_cnt   <= '0;
                brm_cnt  <= '0;
                jmp_cnt  <= '0;
                jmpm_cnt <= '0;
                halt_pc  <= '0;
                state    <= bus.start_i ? RUN : IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start_i) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        // Halt is checked first so it wins over a same-cycle timeout.
                        if (halt_cond) begin
                            state   <= HALTED;
                            halt_pc <= bus.PCF_i;
                        end else begin
                            cyc_cnt  <= cyc_next;
                            ins_cnt  <= ins_next;
                            br_cnt   <= br_next;
                            brm_cnt  <= brm_next;
                            jmp_cnt  <= jmp_next;
                            jmpm_cnt <= jmpm_next;
                            if (budget_hit) begin
                                state <= TIMEOUT;
                            end
                        end
                    end
                    HALTED, TIMEOUT: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    // Previous fetch PCs, tracked in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc1 <= '0;
            prev_pc2 <= '0;
        end else begin
            prev_pc1 <= bus.PCF_i;
            prev_pc2 <= bus.PCF2_i;
        end
    end

    // Read-map selection from current (pre-update) register values.
    always_comb begin
        rd_mux = '0;
        unique case (bus.rd_addr_i)
            3'd0: rd_mux = cyc_cnt;
            3'd1: rd_mux = ins_cnt;
            3'd2: rd_mux = br_cnt;
            3'd3: rd_mux = brm_cnt;
            3'd4: rd_mux = jmp_cnt;
            3'd5: rd_mux = jmpm_cnt;
            3'd6: rd_mux = CNT_W'({timeout, halted, state});
            3'd7: rd_mux = CNT_W'(halt_pc);
        endcase
    end

    // Registered read port; data holds its last value between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                rd_data <= rd_mux;
            end
        end
    end

    assign bus.rd_data_o  = rd_data;
    assign bus.rd_valid_o = rd_valid;
    assign bus.halted_o   = halted;
    assign bus.timeout_o  = timeout;

endmodule

// File: tb/tb_ucsbece154b_perfmon.sv
// Bench for ucsbece154b_perfmon: two instances (32-bit counters with the
// default budget, and 4-bit counters with an 8-cycle budget) share one
// stimulus stream and are compared each cycle against a behavioural model,
// plus hand-computed read-back expectations.
module tb_ucsbece154b_perfmon;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI  = 32'h00a0_0093;
    localparam logic [31:0] ALU_F = 32'h0000_0033;
    localparam logic [6:0]  BR    = 7'b1100011;
    localparam logic [6:0]  JAL   = 7'b1101111;
    localparam logic [6:0]  JALR  = 7'b1100111;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic        start, clear;
    logic [31:0] instr_d, instr_d2;
    logic [6:0]  op_e, op_e2;
    logic        mis, mis2, btf, btf2;
    logic [31:0] pcf, pcf2, instr_f, instr_f2;
    logic        rd_en;
    logic [2:0]  rd_addr;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ucsbece154b_perfmon_if #(.CNT_W(32)) bus_a ();
    ucsbece154b_perfmon_if #(.CNT_W(4))  bus_b ();

    assign bus_a.start_i = start;            assign bus_b.start_i = start;
    assign bus_a.clear_i = clear;            assign bus_b.clear_i = clear;
    assign bus_a.InstrD_i = instr_d;         assign bus_b.InstrD_i = instr_d;
    assign bus_a.InstrD2_i = instr_d2;       assign bus_b.InstrD2_i = instr_d2;
    assign bus_a.opE_i = op_e;               assign bus_b.opE_i = op_e;
    assign bus_a.opE2_i = op_e2;             assign bus_b.opE2_i = op_e2;
    assign bus_a.Mispredict_i = mis;         assign bus_b.Mispredict_i = mis;
    assign bus_a.Mispredict2_i = mis2;       assign bus_b.Mispredict2_i = mis2;
    assign bus_a.BranchTakenF_i = btf;       assign bus_b.BranchTakenF_i = btf;
    assign bus_a.BranchTakenF2_i = btf2;     assign bus_b.BranchTakenF2_i = btf2;
    assign bus_a.PCF_i = pcf;                assign bus_b.PCF_i = pcf;
    assign bus_a.PCF2_i = pcf2;              assign bus_b.PCF2_i = pcf2;
    assign bus_a.InstrF_i = instr_f;         assign bus_b.InstrF_i = instr_f;
    assign bus_a.InstrF2_i = instr_f2;       assign bus_b.InstrF2_i = instr_f2;
    assign bus_a.rd_en_i = rd_en;            assign bus_b.rd_en_i = rd_en;
    assign bus_a.rd_addr_i = rd_addr;        assign bus_b.rd_addr_i = rd_addr;

    ucsbece154b_perfmon #(.CNT_W(32), .MAX_CYCLES(500)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    ucsbece154b_perfmon #(.CNT_W(4), .MAX_CYCLES(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // ---------------- behavioural model ----------------
    // state: 0 idle, 1 run, 2 halted, 3 timeout
    longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
    longint maxc [2] = '{64'd500, 64'd8};
    int     ms   [2];
    longint mc   [2][6];
    longint mhpc [2];
    longint md   [2];
    bit     mh   [2];
    bit     mt   [2];
    bit     mv   [2];
    logic [31:0] mp1, mp2;

    function automatic int issued(input logic [31:0] x);
        return (x != 32'd0 && x != NOP) ? 1 : 0;
    endfunction

    function automatic int jump(input logic [6:0] op);
        return (op == JAL || op == JALR) ? 1 : 0;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mhpc[i] = 0; md[i] = 0; mh[i] = 0; mt[i] = 0; mv[i] = 0;
            for (int k = 0; k < 6; k++) mc[i][k] = 0;
        end
        mp1 = '0;
        mp2 = '0;
    endtask

    task automatic mstep();
        int inc [6];
        bit halt;
        longint v;
        inc[0] = 1;
        inc[1] = issued(instr_d) + issued(instr_d2);
        inc[2] = int'(op_e == BR) + int'(op_e2 == BR);
        inc[3] = int'(op_e == BR && mis) + int'(op_e2 == BR && mis2);
        inc[4] = jump(op_e) + jump(op_e2);
        inc[5] = ((jump(op_e) == 1 && !btf) ? 1 : 0) + ((jump(op_e2) == 1 && !btf2) ? 1 : 0);
        halt = (pcf == mp1) && (instr_f == NOP) && (pcf2 == mp2) && (instr_f2 == NOP);
        for (int i = 0; i < 2; i++) begin
            if (rd_en) begin
                if (rd_addr == 3'd6)      md[i] = longint'(mt[i]) * 8 + longint'(mh[i]) * 4 + longint'(ms[i]);
                else if (rd_addr == 3'd7) md[i] = mhpc[i] & cmax[i];
                else                      md[i] = mc[i][int'(rd_addr)];
            end
            mv[i] = rd_en;
            mh[i] = (ms[i] == 2);
            mt[i] = (ms[i] == 3);
            if (clear) begin
                for (int k = 0; k < 6; k++) mc[i][k] = 0;
                mhpc[i] = 0;
                ms[i] = start ? 1 : 0;
            end else if (ms[i] == 0) begin
                if (start) ms[i] = 1;
            end else if (ms[i] == 1) begin
                if (halt) begin
                    ms[i] = 2;
                    mhpc[i] = longint'(pcf);
                end else begin
                    for (int k = 0; k < 6; k++) begin
                        v = mc[i][k] + inc[k];
                        mc[i][k] = (v > cmax[i]) ? cmax[i] : v;
                    end
                    if (mc[i][0] >= maxc[i]) ms[i] = 3;
                end
            end
        end
        mp1 = pcf;
        mp2 = pcf2;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) mreset();
        else        mstep();
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (reset) begin
            cmp("a.rd_valid", 64'(bus_a.rd_valid_o), 64'(mv[0]));
            cmp("a.rd_data",  64'(bus_a.rd_data_o),  md[0]);
            cmp("a.halted",   64'(bus_a.halted_o),   64'(mh[0]));
            cmp("a.timeout",  64'(bus_a.timeout_o),  64'(mt[0]));
            cmp("b.rd_valid", 64'(bus_b.rd_valid_o), 64'(mv[1]));
            cmp("b.rd_data",  64'(bus_b.rd_data_o),  md[1]);
            cmp("b.halted",   64'(bus_b.halted_o),   64'(mh[1]));
            cmp("b.timeout",  64'(bus_b.timeout_o),  64'(mt[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start = 0; clear = 0;
        instr_d = '0; instr_d2 = '0;
        op_e = '0; op_e2 = '0; mis = 0; mis2 = 0; btf = 1; btf2 = 1;
        pcf = 32'h100; pcf2 = 32'h104; instr_f = ALU_F; instr_f2 = ALU_F;
        rd_en = 0; rd_addr = '0;
    endtask

    // One read with hand-computed expectations for both instances and the model.
    task automatic rd_lit(input logic [2:0] a, input longint ea, input longint eb, input string nm);
        rd_en = 1;
        rd_addr = a;
        tick();
        rd_en = 0;
        cmp({nm, ".a"},       64'(bus_a.rd_data_o), ea);
        cmp({nm, ".b"},       64'(bus_b.rd_data_o), eb);
        cmp({nm, ".a_valid"}, 64'(bus_a.rd_valid_o), 64'd1);
        cmp({nm, ".model_a"}, md[0], ea);
        cmp({nm, ".model_b"}, md[1], eb);
    endtask

    initial begin
        mreset();
        idle();

        // Reset values while reset is held
        tick();
        cmp("rst.a_valid",   64'(bus_a.rd_valid_o), 64'd0);
        cmp("rst.a_data",    64'(bus_a.rd_data_o),  64'd0);
        cmp("rst.a_halted",  64'(bus_a.halted_o),   64'd0);
        cmp("rst.b_timeout", 64'(bus_b.timeout_o),  64'd0);
        #6 reset = 1;
        tick();

        // Dual issue: 10 cycles with both slots busy
        start = 1;
        tick();
        start = 0;
        instr_d = ADDI;
        instr_d2 = ADDI;
        repeat (10) tick();
        instr_d = '0;
        instr_d2 = '0;
        rd_lit(3'd0, 10, 8, "cycles");
        rd_lit(3'd1, 20, 15, "instrs_sat");
        cmp("b.timeout_set", 64'(bus_b.timeout_o), 64'd1);
        cmp("a.timeout_clr", 64'(bus_a.timeout_o), 64'd0);
        rd_lit(3'd6, 1, 11, "status_run_to");

        // Branches in both slots, one mispredicted
        clear = 1; start = 1;
        tick();
        clear = 0; start = 0;
        op_e = BR; mis = 1; op_e2 = BR; mis2 = 0;
        tick();
        op_e = '0; op_e2 = '0; mis = 0;
        rd_lit(3'd2, 2, 2, "branches");
        rd_lit(3'd3, 1, 1, "br_miss");

        // Jumps in slot 2: not predicted taken, then predicted taken
        op_e2 = JAL; btf2 = 0;
        tick();
        op_e2 = JALR; btf2 = 1;
        tick();
        op_e2 = '0;
        rd_lit(3'd4, 2, 2, "jumps");
        rd_lit(3'd5, 1, 1, "jmp_miss");

        // Halt: both fetch slots spin on NOP at fixed PCs
        clear = 1; start = 1;
        tick();
        clear = 0; start = 0;
        pcf = 32'h40; pcf2 = 32'h44; instr_f = NOP; instr_f2 = NOP;
        tick();
        tick();
        pcf = 32'h100; pcf2 = 32'h104; instr_f = ALU_F; instr_f2 = ALU_F;
        instr_d = ADDI; instr_d2 = ADDI;
        tick();
        tick();
        cmp("a.halted_set", 64'(bus_a.halted_o), 64'd1);
        cmp("b.halted_set", 64'(bus_b.halted_o), 64'd1);
        instr_d = '0; instr_d2 = '0;
        rd_lit(3'd7, 64'h40, 0, "halt_pc");
        rd_lit(3'd0, 1, 1, "cycles_frozen");
        rd_lit(3'd1, 0, 0, "instrs_frozen");
        rd_lit(3'd6, 6, 6, "status_halted");

        // Clear together with start
        clear = 1; start = 1;
        tick();
        clear = 0; start = 0;
        rd_lit(3'd0, 0, 0, "cycles_cleared");
        rd_lit(3'd6, 1, 1, "status_cleared");
        cmp("a.halted_clr", 64'(bus_a.halted_o), 64'd0);

        // Reset in the middle of a read
        rd_en = 1; rd_addr = 3'd1;
        tick();
        cmp("mid.a_valid", 64'(bus_a.rd_valid_o), 64'd1);
        #2 reset = 0;
        #1;
        cmp("rstmid.a_valid", 64'(bus_a.rd_valid_o), 64'd0);
        cmp("rstmid.b_valid", 64'(bus_b.rd_valid_o), 64'd0);
        cmp("rstmid.a_data",  64'(bus_a.rd_data_o),  64'd0);
        rd_en = 0;
        #3 reset = 1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
